preg_freelist: RTL and testbench
================================

# preg_freelist

Physical-register free-list controller for the rename/dispatch stage. Hands out up to two free physical registers per cycle to rename and drives the matching busy-table allocate ports. Takes back up to two released registers per cycle from commit. Restores the speculative allocation pointer on a pipeline flush. It is the sole sequencer of the busy table's `alloc_en*`/`alloc_addr*` ports.

## Interface
Parameters:
- `PREG_NUM`, default `` `PREG_SIZE `` (64): total physical registers.
- `ARCH_NUM`, default 32: architectural registers; pregs 0..ARCH_NUM-1 are mapped at reset.
- `FL_DEPTH`, derived as PREG_NUM-ARCH_NUM (32): number of free-list entries.

Ports. One clock; reset is asynchronous and active-low.
- `clock`  in  1  — sole clock; all state updates on posedge.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `alloc_req0`, `alloc_req1`  in  1 each  — rename needs a destination preg in slot 0 / slot 1. req1 is only valid with req0.
- `alloc_ready`  out  1  — list can satisfy the current request this cycle.
- `alloc_en0`, `alloc_en1`  out  1 each  — grant per slot; also the busy-table allocate enables.
- `alloc_addr0`, `alloc_addr1`  out  `` `PREG_RANGE ``  — granted pregs; also the busy-table allocate addresses.
- `free_en0`, `free_en1`  in  1 each  — commit releases an old preg.
- `free_addr0`, `free_addr1`  in  `` `PREG_RANGE ``  — released pregs.
- `commit_alloc_num`  in  2  — number of committed instructions this cycle that own a destination (0..2).
- `flush`  in  1  — redirect; discard all speculative allocations.
- `free_count`  out  $clog2(FL_DEPTH)+1  — registered count of free entries.
- `overflow_err`  out  1  — sticky; a free was attempted while the list was full.

## Operation
- Storage is a circular array of FL_DEPTH preg indices.
- Pointers:
  - `spec_head`: speculative allocation pointer.
  - `arch_head`: committed allocation pointer.
  - `tail`: free write pointer.
  - Each pointer is $clog2(FL_DEPTH)+1 bits wide; the MSB is the wrap bit.
- `free_count` = tail − spec_head, modulo 2·FL_DEPTH.
- Reset:
  - Entry i holds ARCH_NUM+i.
  - spec_head = arch_head = 0; tail = FL_DEPTH with wrap bit set.
  - free_count = FL_DEPTH; overflow_err = 0.
  - All alloc outputs are 0.
- Read ports: `alloc_addr0` = entry[spec_head], `alloc_addr1` = entry[spec_head+1]. Both are combinational from registered state.
- Request size: need = req0 + (req0 & req1).
- `alloc_ready` = (free_count ≥ need) & !flush.
- Grant: `alloc_en0` = req0 & alloc_ready; `alloc_en1` = req1 & req0 & alloc_ready.
- Grants are all-or-nothing. Slot 1 is never granted without slot 0.
- Pointer updates:
  - spec_head advances by the number granted.
  - tail advances by the number of frees. With two frees, free0 is written at tail and free1 at tail+1. A single free1 alone is written at tail.
  - arch_head advances by `commit_alloc_num` every cycle, including a flush cycle.
- Flush: spec_head ← arch_head + commit_alloc_num. Grants are suppressed in that cycle. Frees in that cycle are accepted normally.
- Freed entries become allocatable the cycle after the write. There is no same-cycle free→alloc bypass.
- Overflow: if the free count would exceed FL_DEPTH, the excess free is dropped and overflow_err is set. Only reset clears overflow_err.

## Timing
- Grant latency is 0 cycles: request → alloc_en/alloc_addr in the same cycle.
- The busy bit is set at the next edge.
- `free_count` reflects grants and frees of cycle N in cycle N+1.
- Simultaneous grant, free and commit in one cycle: all pointers update independently at the same edge.
- Wrap-around: pointers roll over at FL_DEPTH and toggle the wrap bit. Full and empty are distinguished by the wrap bit.
- Empty (free_count < need): alloc_ready = 0 and no grant. Rename stalls and holds its request.
- A reset asserted mid-operation returns all state to reset values immediately (asynchronously), regardless of pending requests.

## Configuration
- `FREELIST_PERF_EN`:
  - Defined: adds output `perf_stall_cnt` (32 bits). It increments each cycle that req0 & !alloc_ready & !flush, saturates at all-ones, and resets to 0.
  - Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package holds:
  - `FL_DEPTH`.
  - The pointer width constant.
  - A `fl_ptr_t` typedef (wrap bit plus index).
  - A `pointer_add` function (pointer plus 0..2 with wrap).
- One sub-module: `fl_ptr_reg`. It is a pointer register with async reset value, increment-by-n and load, and is instantiated three times (spec_head, arch_head, tail).
- Target size: 150–250 lines of RTL.

## Test plan
- Reset, then req0 = req1 = 1 → alloc_addr0 = 32, alloc_addr1 = 33, alloc_en0/1 = 1; next cycle free_count = 30.
- Allocate 32 pregs, then req0 = 1 → alloc_ready = 0, no grant. Free preg 5 → next cycle alloc_addr0 = 5, granted.
- free_count = 1 with req0 = req1 = 1 → no grant for either slot. With req0 only → grant.
- Allocate 6, commit_alloc_num = 2, then flush → spec_head = arch_head (index 2), and grants are suppressed in the flush cycle. free_count = 30 next cycle; the following cycle alloc_addr0 = 34.
- Wrap: run 40 alloc/free pairs → addresses recycle in FIFO order, free_count stays constant, and the wrap bit toggles.
- At full, free_en0 = 1 → overflow_err = 1 and free_count stays 32. `FREELIST_PERF_EN` build: 5 stalled cycles → perf_stall_cnt = 5.

Source files
------------

// File: rtl/preg_freelist_pkg.sv
// Free-list types and pointer arithmetic shared by the free-list controller and its pointer registers.
// Pointers carry a wrap bit above the index so that full and empty can be told apart.
`ifndef PREG_SIZE
`define PREG_SIZE 64
`endif
`ifndef PREG_RANGE
`define PREG_RANGE [$clog2(`PREG_SIZE)-1:0]
`endif

package preg_freelist_pkg;

  localparam int FL_DEPTH = `PREG_SIZE - 32;
  localparam int IDX_W    = $clog2(FL_DEPTH);
  localparam int PTR_W    = IDX_W + 1;

  typedef struct packed {
    logic             wrap;
    logic [IDX_W-1:0] idx;
  } fl_ptr_t;

  localparam fl_ptr_t TAIL_RST = {1'b1, {IDX_W{1'b0}}};

  function automatic fl_ptr_t pointer_add(input fl_ptr_t p, input logic [1:0] n);
    fl_ptr_t        r;
    logic [IDX_W:0] s;
    s = {1'b0, p.idx} + (IDX_W+1)'(n);
    if (s >= (IDX_W+1)'(FL_DEPTH)) begin
      r.idx  = IDX_W'(s - (IDX_W+1)'(FL_DEPTH));
      r.wrap = ~p.wrap;
    end else begin
      r.idx  = s[IDX_W-1:0];
      r.wrap = p.wrap;
    end
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(FL_DEPTH - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  // Distance from b forward to a; equal indices mean full when the wrap bits differ.
  function automatic logic [PTR_W-1:0] ptr_diff(input fl_ptr_t a, input fl_ptr_t b);
    if (a.wrap == b.wrap) return {1'b0, a.idx} - {1'b0, b.idx};
    else                  return PTR_W'(FL_DEPTH) + {1'b0, a.idx} - {1'b0, b.idx};
  endfunction

endpackage

// File: rtl/fl_ptr_reg.sv
// Free-list pointer register: async reset value, load (priority) or advance by 0..2 with wrap.
// Updates at the next clock edge; no flow control of its own.
module fl_ptr_reg
  import preg_freelist_pkg::*;
#(
  parameter fl_ptr_t RST_VAL = '0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_load,
  input  fl_ptr_t    i_load_val,
  input  logic [1:0] i_inc,
  output fl_ptr_t    o_ptr
);

  fl_ptr_t r_ptr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    r_ptr <= RST_VAL;
    else if (i_load) r_ptr <= i_load_val;
    else             r_ptr <= pointer_add(r_ptr, i_inc);
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/preg_freelist.sv
// Physical-register free list: 0-cycle grant of up to two pregs, all-or-nothing, stalls rename when short;
// frees land at the tail and become allocatable next cycle. Optional stall counter under FREELIST_PERF_EN.
module preg_freelist
  import preg_freelist_pkg::*;
#(
  parameter int PREG_NUM = `PREG_SIZE,
  parameter int ARCH_NUM = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             alloc_req0,
  input  logic             alloc_req1,
  output logic             alloc_ready,
  output logic             alloc_en0,
  output logic             alloc_en1,
  output logic `PREG_RANGE alloc_addr0,
  output logic `PREG_RANGE alloc_addr1,
  input  logic             free_en0,
  input  logic             free_en1,
  input  logic `PREG_RANGE free_addr0,
  input  logic `PREG_RANGE free_addr1,
  input  logic [1:0]       commit_alloc_num,
  input  logic             flush,
  output logic [PTR_W-1:0] free_count,
  output logic             overflow_err
`ifdef FREELIST_PERF_EN
  ,
  output logic [31:0]      perf_stall_cnt
`endif
);

  localparam int PREG_W = $clog2(PREG_NUM);
  localparam int CW     = PTR_W + 1;

  logic [PREG_W-1:0] r_entry [FL_DEPTH];
  logic              r_overflow_err;

  fl_ptr_t          w_spec, w_arch, w_tail, w_flush_ptr;
  logic [1:0]       w_need, w_ngrant, w_nfree;
  logic [CW-1:0]    w_space;
  logic             w_acc0, w_acc1;
  logic [IDX_W-1:0] w_wr1_idx;

  assign free_count = ptr_diff(w_tail, w_spec);

  assign w_need      = {1'b0, alloc_req0} + {1'b0, alloc_req0 & alloc_req1};
  assign alloc_ready = (free_count >= PTR_W'(w_need)) && !flush;
  assign alloc_en0   = alloc_req0 & alloc_ready;
  assign alloc_en1   = alloc_req1 & alloc_req0 & alloc_ready;
  assign alloc_addr0 = r_entry[w_spec.idx];
  assign alloc_addr1 = r_entry[idx_inc(w_spec.idx)];
  assign w_ngrant    = {1'b0, alloc_en0} + {1'b0, alloc_en1};

  // Room left after this cycle's grants; frees beyond it are dropped, free0 first in line.
  assign w_space   = CW'(FL_DEPTH) - CW'(free_count) + CW'(w_ngrant);
  assign w_acc0    = free_en0 && (w_space >= CW'(1));
  assign w_acc1    = free_en1 && (w_space >= (w_acc0 ? CW'(2) : CW'(1)));
  assign w_nfree   = {1'b0, w_acc0} + {1'b0, w_acc1};
  assign w_wr1_idx = w_acc0 ? idx_inc(w_tail.idx) : w_tail.idx;

  assign w_flush_ptr = pointer_add(w_arch, commit_alloc_num);

  fl_ptr_reg #(.RST_VAL('0)) u_spec_head (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_load     (flush),
    .i_load_val (w_flush_ptr),
    .i_inc      (w_ngrant),
    .o_ptr      (w_spec)
  );

  fl_ptr_reg #(.RST_VAL('0)) u_arch_head (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_inc      (commit_alloc_num),
    .o_ptr      (w_arch)
  );

  fl_ptr_reg #(.RST_VAL(TAIL_RST)) u_tail (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_inc      (w_nfree),
    .o_ptr      (w_tail)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FL_DEPTH; i++) r_entry[i] <= PREG_W'(ARCH_NUM + i);
    end else begin
      if (w_acc0) r_entry[w_tail.idx] <= free_addr0;
      if (w_acc1) r_entry[w_wr1_idx]  <= free_addr1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_overflow_err <= 1'b0;
    else          r_overflow_err <= r_overflow_err | (free_en0 & ~w_acc0) | (free_en1 & ~w_acc1);
  end

  assign overflow_err = r_overflow_err;

`ifdef FREELIST_PERF_EN
  logic [31:0] r_perf_stall_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_perf_stall_cnt <= '0;
    else if (alloc_req0 && !alloc_ready && !flush && (r_perf_stall_cnt != '1))
      r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
  end

  assign perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule

// File: tb/tb_preg_freelist.sv
// Bench for preg_freelist: queue-based model checked every cycle plus directed literal expectations.
module tb_preg_freelist;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       alloc_req0, alloc_req1;
  logic       alloc_ready, alloc_en0, alloc_en1;
  logic [5:0] alloc_addr0, alloc_addr1;
  logic       free_en0, free_en1;
  logic [5:0] free_addr0, free_addr1;
  logic [1:0] commit_alloc_num;
  logic       flush;
  logic [5:0] free_count;
  logic       overflow_err;
`ifdef FREELIST_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  preg_freelist dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .alloc_req0       (alloc_req0),
    .alloc_req1       (alloc_req1),
    .alloc_ready      (alloc_ready),
    .alloc_en0        (alloc_en0),
    .alloc_en1        (alloc_en1),
    .alloc_addr0      (alloc_addr0),
    .alloc_addr1      (alloc_addr1),
    .free_en0         (free_en0),
    .free_en1         (free_en1),
    .free_addr0       (free_addr0),
    .free_addr1       (free_addr1),
    .commit_alloc_num (commit_alloc_num),
    .flush            (flush),
    .free_count       (free_count),
    .overflow_err     (overflow_err)
`ifdef FREELIST_PERF_EN
    ,
    .perf_stall_cnt   (perf_stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: fl_q holds allocatable pregs in hand-out order, sq_q the granted but uncommitted ones.
  int fl_q[$];
  int sq_q[$];
  bit m_ovf;
  int m_perf;

  always @(negedge clock) begin
    int need;
    bit rdy, e0, e1;
    if (!reset_n) begin
      fl_q.delete();
      sq_q.delete();
      for (int i = 0; i < 32; i++) fl_q.push_back(32 + i);
      m_ovf  = 0;
      m_perf = 0;
    end
    need = alloc_req0 ? (alloc_req1 ? 2 : 1) : 0;
    rdy  = (fl_q.size() >= need) && !flush;
    e0   = alloc_req0 && rdy;
    e1   = alloc_req0 && alloc_req1 && rdy;
    chk("m_ready", alloc_ready, rdy);
    chk("m_en0", alloc_en0, e0);
    chk("m_en1", alloc_en1, e1);
    if (fl_q.size() >= 1) chk("m_addr0", alloc_addr0, fl_q[0]);
    if (fl_q.size() >= 2) chk("m_addr1", alloc_addr1, fl_q[1]);
    chk("m_count", free_count, fl_q.size());
    chk("m_ovf", overflow_err, m_ovf);
`ifdef FREELIST_PERF_EN
    chk("m_perf", perf_stall_cnt, m_perf);
`endif
    if (reset_n) begin
      if (alloc_req0 && !rdy && !flush) m_perf++;
      if (e0) sq_q.push_back(fl_q.pop_front());
      if (e1) sq_q.push_back(fl_q.pop_front());
      if (free_en0) begin
        if (fl_q.size() < 32) fl_q.push_back(free_addr0); else m_ovf = 1;
      end
      if (free_en1) begin
        if (fl_q.size() < 32) fl_q.push_back(free_addr1); else m_ovf = 1;
      end
      for (int i = 0; i < commit_alloc_num; i++)
        if (sq_q.size() > 0) void'(sq_q.pop_front());
      if (flush) begin
        for (int i = sq_q.size() - 1; i >= 0; i--) fl_q.push_front(sq_q[i]);
        sq_q.delete();
      end
    end
  end

  task automatic zero_inputs();
    alloc_req0 = 0; alloc_req1 = 0;
    free_en0 = 0; free_en1 = 0; free_addr0 = 0; free_addr1 = 0;
    commit_alloc_num = 0; flush = 0;
  endtask

  // Drive one cycle's inputs just after the edge, then settle before literal checks.
  task automatic cyc(input logic r0, input logic r1, input logic f0, input int a0,
                     input logic f1, input int a1, input int cn, input logic fl);
    @(posedge clock); #1;
    alloc_req0 = r0; alloc_req1 = r1;
    free_en0 = f0; free_addr0 = 6'(a0);
    free_en1 = f1; free_addr1 = 6'(a1);
    commit_alloc_num = 2'(cn); flush = fl;
    #2;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset_n = 0;
    zero_inputs();
    #1;
    chk("rst_count", free_count, 32);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_en0", alloc_en0, 0);
    chk("rst_en1", alloc_en1, 0);
    @(posedge clock); #3;
    reset_n = 1;
  endtask

  initial begin
    reset_n = 0;
    zero_inputs();
    do_reset();

    // Pair grant from a fresh list, then drain to empty and stall.
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    chk("first_addr0", alloc_addr0, 32);
    chk("first_addr1", alloc_addr1, 33);
    chk("first_en0", alloc_en0, 1);
    chk("first_en1", alloc_en1, 1);
    idle();
    chk("count_after_pair", free_count, 30);
    repeat (15) cyc(1, 1, 0, 0, 0, 0, 0, 0);
    idle();
    chk("count_empty", free_count, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("empty_ready", alloc_ready, 0);
      chk("empty_en0", alloc_en0, 0);
    end
    cyc(1, 0, 1, 5, 0, 0, 0, 0);
    chk("no_bypass_en0", alloc_en0, 0);
`ifdef FREELIST_PERF_EN
    chk("perf_five", perf_stall_cnt, 5);
`endif
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("refill_addr0", alloc_addr0, 5);
    chk("refill_en0", alloc_en0, 1);

    // One free entry: a pair request is refused whole, a single is granted.
    cyc(0, 0, 1, 7, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    chk("one_left_en0", alloc_en0, 0);
    chk("one_left_en1", alloc_en1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("one_left_single", alloc_en0, 1);
    chk("one_left_addr", alloc_addr0, 7);

    // Lone free1 goes at the tail, then a double free keeps free0-before-free1 order.
    cyc(0, 0, 0, 0, 1, 11, 0, 0);
    cyc(0, 0, 1, 12, 1, 13, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    chk("order_count", free_count, 3);
    chk("order_addr0", alloc_addr0, 11);
    chk("order_addr1", alloc_addr1, 12);
    idle();
    chk("order_left", free_count, 1);
    chk("order_next", alloc_addr0, 13);

    // Flush after six grants with two commits in the flush cycle.
    do_reset();
    repeat (3) cyc(1, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 2, 1);
    chk("flush_en0", alloc_en0, 0);
    chk("flush_ready", alloc_ready, 0);
    idle();
    chk("flush_count", free_count, 30);
    chk("flush_addr0", alloc_addr0, 34);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("post_flush_en0", alloc_en0, 1);
    chk("post_flush_addr", alloc_addr0, 34);

    // Forty grant/free/commit cycles wrap both pointers past the end of the array.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      cyc(1, 0, 1, 32 + (i % 32), 0, 0, 1, 0);
      chk("wrap_addr0", alloc_addr0, 32 + (i % 32));
      chk("wrap_en0", alloc_en0, 1);
      chk("wrap_count", free_count, 32);
    end
    idle();
    chk("wrap_final_count", free_count, 32);

    // Free into a full list.
    cyc(0, 0, 1, 9, 0, 0, 0, 0);
    idle();
    chk("ovf_set", overflow_err, 1);
    chk("ovf_count", free_count, 32);
    idle();
    chk("ovf_sticky", overflow_err, 1);
    do_reset();
    idle();
    chk("ovf_cleared", overflow_err, 0);
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
